// File: rtl/lbm_pkg.sv
// lbm_pkg: D2Q9 constants, sequencer states and saturation helper
package lbm_pkg;
  localparam int Q = 9;
  localparam logic signed [1:0] CX [Q] = '{2'sd0, 2'sd1, 2'sd0, -2'sd1, 2'sd0, 2'sd1, -2'sd1, -2'sd1, 2'sd1};
  localparam logic signed [1:0] CY [Q] = '{2'sd0, 2'sd0, 2'sd1, 2'sd0, -2'sd1, 2'sd1, 2'sd1, -2'sd1, -2'sd1};
  typedef enum logic [2:0] {IDLE, ACCUM, SAT, DXS, DXW, DYS, DYW, DONE} state_e;
  // Clamp a signed value to the signed range of w bits; the caller truncates the result to w bits.
  function automatic logic [63:0] saturate(input logic signed [63:0] v, input int w, output logic clip);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = ~hi;
    clip = (v > hi) || (v < lo);
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction
endpackage

// File: rtl/lbm_macro_seq.sv
// lbm_macro_seq: accumulates rho/mx/my of one D2Q9 node and sequences ux, uy divisions
module lbm_macro_seq
  import lbm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FBITS = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [Q*WIDTH-1:0] f_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   rho,
  output logic [WIDTH-1:0]   ux,
  output logic [WIDTH-1:0]   uy,
  output logic               err_dbz,
  output logic               err_ovf,
  output logic               err_sat,
  output logic               div_start,
  output logic [WIDTH-1:0]   div_x,
  output logic [WIDTH-1:0]   div_y,
  input  logic               div_busy,
  input  logic               div_valid,
  input  logic               div_dbz,
  input  logic               div_ovf,
  input  logic [WIDTH-1:0]   div_q
);
  localparam int AW = WIDTH + 4;
  if (FBITS < 1 || FBITS >= WIDTH) begin : g_bad_fbits
    $error("FBITS must lie in 1..WIDTH-1");
  end
  state_e state_q, state_d;
  logic [Q*WIDTH-1:0] f_q, f_d;
  logic [3:0] k_q, k_d;
  logic signed [AW-1:0] acc_rho_q, acc_rho_d, acc_mx_q, acc_mx_d, acc_my_q, acc_my_d, fk;
  logic [WIDTH-1:0] rho_q, rho_d, mx_q, mx_d, my_q, my_d, ux_q, ux_d, uy_q, uy_d;
  logic [WIDTH-1:0] div_x_q, div_x_d, div_y_q, div_y_d, rho_s, mx_s, my_s, q_sel;
  logic div_start_q, div_start_d, err_dbz_q, err_dbz_d, err_ovf_q, err_ovf_d, err_sat_q, err_sat_d;
  logic clip_r, clip_x, clip_y, div_done;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign rho       = rho_q;
  assign ux        = ux_q;
  assign uy        = uy_q;
  assign err_dbz   = err_dbz_q;
  assign err_ovf   = err_ovf_q;
  assign err_sat   = err_sat_q;
  assign div_start = div_start_q;
  assign div_x     = div_x_q;
  assign div_y     = div_y_q;
  // Next-state and datapath: the low word of f_q is always the distribution for step k.
  always_comb begin
    rho_s = WIDTH'(saturate(64'(acc_rho_q), WIDTH, clip_r));
    mx_s = WIDTH'(saturate(64'(acc_mx_q), WIDTH, clip_x));
    my_s = WIDTH'(saturate(64'(acc_my_q), WIDTH, clip_y));
    fk = {{4{f_q[WIDTH-1]}}, f_q[WIDTH-1:0]};
    div_done = !div_start_q && !div_busy;
    q_sel = (div_valid && !div_dbz && !div_ovf) ? div_q : '0;
    state_d = state_q;
    f_d = f_q;
    k_d = k_q;
    acc_rho_d = acc_rho_q;
    acc_mx_d = acc_mx_q;
    acc_my_d = acc_my_q;
    rho_d = rho_q;
    mx_d = mx_q;
    my_d = my_q;
    ux_d = ux_q;
    uy_d = uy_q;
    div_x_d = div_x_q;
    div_y_d = div_y_q;
    div_start_d = 1'b0;
    err_dbz_d = err_dbz_q;
    err_ovf_d = err_ovf_q;
    err_sat_d = err_sat_q;
    case (state_q)
      IDLE: if (in_valid) begin
        f_d = f_in;
        k_d = '0;
        acc_rho_d = '0;
        acc_mx_d = '0;
        acc_my_d = '0;
        state_d = ACCUM;
      end
      ACCUM: begin
        acc_rho_d = acc_rho_q + fk;
        acc_mx_d = acc_mx_q + (CX[k_q] == 2'sd1 ? fk : CX[k_q] == -2'sd1 ? -fk : '0);
        acc_my_d = acc_my_q + (CY[k_q] == 2'sd1 ? fk : CY[k_q] == -2'sd1 ? -fk : '0);
        f_d = f_q >> WIDTH;
        k_d = k_q + 4'd1;
        state_d = (k_q == 4'(Q - 1)) ? SAT : ACCUM;
      end
      SAT: begin
        rho_d = rho_s;
        mx_d = mx_s;
        my_d = my_s;
        err_sat_d = clip_r | clip_x | clip_y;
        state_d = DXS;
      end
      DXS: if (!div_busy) begin
        div_x_d = mx_q;
        div_y_d = rho_q;
        div_start_d = 1'b1;
        state_d = DXW;
      end
      DXW: if (div_done) begin
        ux_d = q_sel;
        uy_d = div_dbz ? '0 : uy_q;
        err_dbz_d = div_dbz;
        err_ovf_d = div_ovf && !div_dbz;
        state_d = div_dbz ? DONE : DYS;
      end
      DYS: if (!div_busy) begin
        div_x_d = my_q;
        div_y_d = rho_q;
        div_start_d = 1'b1;
        state_d = DYW;
      end
      DYW: if (div_done) begin
        uy_d = q_sel;
        err_dbz_d = err_dbz_q | div_dbz;
        err_ovf_d = err_ovf_q | (div_ovf && !div_dbz);
        state_d = DONE;
      end
      DONE: if (out_ready) begin
        err_dbz_d = 1'b0;
        err_ovf_d = 1'b0;
        err_sat_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers; reset abandons any division in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      f_q <= '0;
      k_q <= '0;
      acc_rho_q <= '0;
      acc_mx_q <= '0;
      acc_my_q <= '0;
      rho_q <= '0;
      mx_q <= '0;
      my_q <= '0;
      ux_q <= '0;
      uy_q <= '0;
      div_x_q <= '0;
      div_y_q <= '0;
      div_start_q <= 1'b0;
      err_dbz_q <= 1'b0;
      err_ovf_q <= 1'b0;
      err_sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      f_q <= f_d;
      k_q <= k_d;
      acc_rho_q <= acc_rho_d;
      acc_mx_q <= acc_mx_d;
      acc_my_q <= acc_my_d;
      rho_q <= rho_d;
      mx_q <= mx_d;
      my_q <= my_d;
      ux_q <= ux_d;
      uy_q <= uy_d;
      div_x_q <= div_x_d;
      div_y_q <= div_y_d;
      div_start_q <= div_start_d;
      err_dbz_q <= err_dbz_d;
      err_ovf_q <= err_ovf_d;
      err_sat_q <= err_sat_d;
    end
  end
endmodule

// File: tb/tb_lbm_macro_seq.sv
// tb_lbm_macro_seq: directed vectors against lbm_macro_seq with a behavioural divider
module tb_lbm_macro_seq;
  localparam int W = 32;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [9*W-1:0] f_in = '0;
  logic in_ready, out_valid, err_dbz, err_ovf, err_sat, div_start;
  logic [W-1:0] rho, ux, uy, div_x, div_y;
  logic div_busy = 1'b0, div_valid = 1'b0, div_dbz = 1'b0, div_ovf = 1'b0;
  logic [W-1:0] div_q = '0, m_x = '0, m_y = '0;
  int lat = 6, m_cnt = 0, n_start = 0, n_bad = 0, n_chk = 0, n_pass = 0;
  logic [W-1:0] cap_x [64], cap_y [64];
  localparam logic [9*W-1:0] S1 = {{7{32'h0}}, 32'h00800000, 32'h00800000};
  localparam logic [9*W-1:0] S2 = {{5{32'h0}}, 32'h00400000, 32'h0, 32'h0, 32'h00C00000};
  localparam logic [9*W-1:0] S4 = {{5{32'h0}}, 32'hFF000001, 32'h0, 32'h01000000, 32'h0};
  localparam logic [9*W-1:0] SS = {9{32'h7FFFFFFF}};

  lbm_macro_seq #(.WIDTH(W), .FBITS(24)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .f_in(f_in),
    .out_valid(out_valid), .out_ready(out_ready), .rho(rho), .ux(ux), .uy(uy),
    .err_dbz(err_dbz), .err_ovf(err_ovf), .err_sat(err_sat), .div_start(div_start),
    .div_x(div_x), .div_y(div_y), .div_busy(div_busy), .div_valid(div_valid),
    .div_dbz(div_dbz), .div_ovf(div_ovf), .div_q(div_q)
  );

  always #5 clk = ~clk;

  function automatic logic signed [63:0] qdiv(input logic [W-1:0] x, input logic [W-1:0] y);
    return ($signed({{32{x[31]}}, x}) <<< 24) / $signed({{32{y[31]}}, y});
  endfunction

  // Divider without reset: busy for lat cycles after a start, then one-cycle result flags.
  always @(posedge clk) begin
    div_valid <= 1'b0;
    div_dbz <= 1'b0;
    div_ovf <= 1'b0;
    if (div_busy) begin
      if (m_cnt == 1) begin
        div_busy <= 1'b0;
        if (m_y == '0) div_dbz <= 1'b1;
        else if (qdiv(m_x, m_y) > 64'sh7FFFFFFF || qdiv(m_x, m_y) < -64'sh80000000) div_ovf <= 1'b1;
        else begin
          div_valid <= 1'b1;
          div_q <= W'(qdiv(m_x, m_y));
        end
      end
      m_cnt <= m_cnt - 1;
    end else if (div_start) begin
      div_busy <= 1'b1;
      m_cnt <= lat;
      m_x <= div_x;
      m_y <= div_y;
    end
  end

  // Record operands of every start pulse and any start issued while the divider is busy.
  always @(posedge clk) begin
    if (div_start) begin
      cap_x[n_start % 64] <= div_x;
      cap_y[n_start % 64] <= div_y;
      n_start <= n_start + 1;
      if (div_busy) n_bad <= n_bad + 1;
    end
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic send(input logic [9*W-1:0] f);
    @(negedge clk);
    f_in = f;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    for (int i = 0; i < 2000 && !out_valid; i++) @(negedge clk);
    check("out_valid_seen", 32'(out_valid), 32'd1);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_released"}, {27'd0, out_valid, in_ready, err_dbz, err_ovf, err_sat}, 32'b01000);
  endtask

  task automatic result(input string tag, input logic [W-1:0] r, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [2:0] e);
    check({tag, "_rho"}, rho, r);
    check({tag, "_ux"}, ux, x);
    check({tag, "_uy"}, uy, y);
    check({tag, "_err"}, {29'd0, err_dbz, err_ovf, err_sat}, {29'd0, e});
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    int s, nchg, b;
    logic [W-1:0] r0, x0, y0;
    repeat (3) @(negedge clk);
    check("rst_hs", {29'd0, in_ready, out_valid, div_start}, 32'b100);
    check("rst_rho", rho, '0);
    check("rst_uxuy", ux | uy, '0);
    check("rst_divxy", div_x | div_y, '0);
    check("rst_err", {29'd0, err_dbz, err_ovf, err_sat}, '0);
    rst = 1'b0;
    s = n_start;
    send(S1);
    wait_out();
    result("s1", 32'h01000000, 32'h00800000, 32'h0, 3'b000);
    check("s1_starts", n_start - s, 2);
    check("s1_x0", cap_x[s % 64], 32'h00800000);
    check("s1_y0", cap_y[s % 64], 32'h01000000);
    check("s1_x1", cap_x[(s + 1) % 64], 32'h0);
    release_out("s1");
    send(S2);
    wait_out();
    result("s2", 32'h01000000, 32'hFFC00000, 32'h0, 3'b000);
    release_out("s2");
    s = n_start;
    send('0);
    wait_out();
    result("s3", 32'h0, 32'h0, 32'h0, 3'b100);
    check("s3_starts", n_start - s, 1);
    release_out("s3");
    s = n_start;
    send(S4);
    wait_out();
    result("s4", 32'h00000001, 32'h0, 32'h0, 3'b010);
    check("s4_starts", n_start - s, 2);
    release_out("s4");
    send(SS);
    wait_out();
    result("sat", 32'h7FFFFFFF, 32'h0, 32'h0, 3'b001);
    release_out("sat");
    send(S1);
    wait_out();
    r0 = rho;
    x0 = ux;
    y0 = uy;
    s = n_start;
    f_in = S2;
    in_valid = 1'b1;
    nchg = 0;
    repeat (20) begin
      @(negedge clk);
      if ({rho, ux, uy, err_dbz, err_ovf, err_sat, out_valid, in_ready} !== {r0, x0, y0, 3'b000, 2'b10}) nchg++;
    end
    check("bp_stable", nchg, 0);
    check("bp_ux", x0, 32'h00800000);
    in_valid = 1'b0;
    release_out("bp");
    repeat (3) @(negedge clk);
    check("bp_not_taken", {31'd0, in_ready}, 32'd1);
    check("bp_no_start", n_start - s, 0);
    lat = 40;
    s = n_start;
    send(S1);
    for (int i = 0; i < 200 && n_start == s; i++) @(negedge clk);
    check("s6_first_start", n_start - s, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("s6_rst_idle", {30'd0, in_ready, out_valid}, 32'b10);
    b = n_bad;
    send(S2);
    wait_out();
    result("s6", 32'h01000000, 32'hFFC00000, 32'h0, 3'b000);
    check("s6_start_while_busy", n_bad - b, 0);
    check("s6_starts", n_start - s, 3);
    release_out("s6");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
